sramlike_mem_resp: RTL
======================

Name: sramlike_mem_resp

Overview:
- Responder (slave) end of the sram-like data-memory interface that the pipeline's memory stage drives as initiator.
- Accepts one read or write transfer at a time, with programmable address-phase and data-phase latency, and backs it with an internal word-organised RAM.
- Used as the data-side memory model and latency stress source in core simulation; synthesizable as a small on-chip scratch memory.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two; AW = log2(DEPTH).
- ADDR_LAT, 0, cycles req must be held before addr_ok; 0..15.
- DATA_LAT, 1, cycles from acceptance edge to data_ok; 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  transfer request from initiator.
- wr  in  1  1 = write, 0 = read; valid with req.
- size  in  2  0 byte, 1 halfword, 2 word; 3 is treated as word.
- addr  in  32  byte address.
- wdata  in  32  write data, lane-aligned by initiator.
- addr_ok  out  1  request accepted this cycle (req & addr_ok).
- data_ok  out  1  one-cycle pulse: read data valid / write complete.
- rdata  out  32  read word.
- misalign  out  1  pulses with data_ok when the completed transfer was misaligned.

Behaviour:
- Reset (rst=0, async) values: addr_ok=0, data_ok=0, rdata=0, misalign=0, FSM=IDLE, counters=0. RAM contents are not reset.
- Reset asserted mid-transfer: the outstanding transfer is dropped and no data_ok is issued. A write already committed at its acceptance edge stays in the RAM.
- FSM states and transitions:
  - IDLE:
    - If ADDR_LAT=0: addr_ok = req (combinational).
    - Otherwise: wait_cnt counts consecutive cycles with req=1. addr_ok=1 in the cycle where req=1 and wait_cnt==ADDR_LAT.
    - If req drops before acceptance, wait_cnt clears to 0.
  - Acceptance edge (req & addr_ok): latch wr, size, addr[1:0]; go to BUSY with lat_cnt=1.
  - BUSY: addr_ok=0. lat_cnt increments each cycle. When lat_cnt==DATA_LAT, assert data_ok for that cycle, then go to IDLE.
  - data_ok cycle: addr_ok=0. A new request can therefore be accepted no earlier than the cycle after data_ok.
- Single outstanding transfer only. Minimum spacing between acceptances = DATA_LAT+1 cycles.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses alias/wrap modulo DEPTH*4.
- Byte enables:
  - size 0: one lane selected by addr[1:0].
  - size 1: addr[1]=0 gives 4'b0011; addr[1]=1 gives 4'b1100.
  - size 2/3: 4'b1111.
- Misaligned: size 1 with addr[0]=1, or size 2/3 with addr[1:0]!=0.
  - Misaligned write: RAM unchanged.
  - Misaligned read: returns the full word.
  - In both cases misalign=1 in the data_ok cycle.
- Write commit: enabled lanes of wdata are written to the RAM at the acceptance edge.
- Read sampling: the RAM word is read at the acceptance edge, so a read sees all earlier writes. rdata is loaded into the output register and is valid from the data_ok cycle.
- rdata holds its value until the next read's data_ok; writes do not change rdata.
- Read data is always the full word; lane extraction and sign extension belong to the initiator.
- wr/size/addr/wdata are ignored when req=0 or while BUSY.

Optional Feature:
- Macro: SRAMLIKE_RAND_STALL_EN.
- Defined:
  - A 16-bit Galois LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - In IDLE, addr_ok is additionally suppressed when lfsr[0]=1.
  - In BUSY, lat_cnt does not increment when lfsr[1]=1.
  - Result: pseudo-random extra address and data stalls, repeatable from reset.
- Not defined: no LFSR is built, and latencies are exactly ADDR_LAT and DATA_LAT.

Test Plan:
- ADDR_LAT=0, DATA_LAT=1: word write 0x0000_0010 <- 0xDEADBEEF, then word read 0x10 -> addr_ok same cycle as req; data_ok one cycle after acceptance; rdata=0xDEADBEEF; misalign=0.
- Byte write 0x11 <- wdata 0x0000_5500 (size 0) over a word previously 0xDEADBEEF, then read 0x10 -> rdata=0xDEAD55EF.
- Halfword write to 0x13 (misaligned) with wdata 0x1234_5678 -> data_ok with misalign=1; a subsequent read of 0x10 is unchanged.
- ADDR_LAT=3, DATA_LAT=4:
  - req held -> addr_ok on the 4th req cycle; data_ok exactly 4 cycles after acceptance.
  - Second req held continuously -> accepted no earlier than the cycle after data_ok.
- DEPTH=1024: write 0x0000_1004 <- 0xA5A5A5A5, read 0x0000_0004 -> rdata=0xA5A5A5A5 (wrap).
- rst pulled low while in BUSY with DATA_LAT=5 -> all outputs 0 immediately; no data_ok after release; the next transfer completes normally.

Source files
------------

// File: rtl/sramlike_mem_resp_if.sv
// sramlike_mem_if: sram-like data-memory bus between the pipeline memory
// stage (master) and a memory responder (slave).
//
// Handshake: an address phase completes on a rising edge where
// req & addr_ok are both 1. wr/size/addr/wdata only count on that edge.
// The transfer then completes with a one-cycle data_ok pulse. rdata and
// misalign are valid in that cycle. Only one transfer is outstanding.
interface sramlike_mem_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        misalign;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata, misalign
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata, misalign
    );
endinterface

// File: rtl/sramlike_mem_resp.sv
// sramlike_mem_resp: responder end of the sram-like data-memory bus.
// Handles one transfer at a time, with programmable address and data
// latency, and backs it with a word-organised RAM of DEPTH 32-bit words.
// Optional macro SRAMLIKE_RAND_STALL_EN adds LFSR-driven random stalls.
// The address and data phases complete as described in sramlike_mem_if.
module sramlike_mem_resp #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_LAT = 0,
    parameter int unsigned DATA_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    sramlike_mem_if.slave  bus,
    output logic           state_dbg
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic        wr_q, wr_d;
    logic        mis_q, mis_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        data_ok_q, data_ok_d;
    logic        misalign_q, misalign_d;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic          req_mis;
    logic          addr_stall;
    logic          lat_stall;
    logic          unused_addr;

    assign idx         = bus.addr[AW+1:2];
    assign unused_addr = ^bus.addr[31:AW+2];

`ifdef SRAMLIKE_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Galois LFSR, taps 16,14,13,11; shifts right with feedback mask 0xB400
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // LFSR state; restarts from the same seed so stall patterns repeat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= lfsr_d;
    end

    assign addr_stall = lfsr_q[0];
    assign lat_stall  = lfsr_q[1];
`else
    assign addr_stall = 1'b0;
    assign lat_stall  = 1'b0;
`endif

    // Lane enables and misalignment of the request currently on the bus
    always_comb begin
        case (bus.size)
            2'd0:    be = 4'b0001 << bus.addr[1:0];
            2'd1:    be = bus.addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        req_mis = ((bus.size == 2'd1) && bus.addr[0]) ||
                  (bus.size[1] && (bus.addr[1:0] != 2'b00));
    end

    // addr_ok must follow req in the same cycle, so it is decoded, not registered.
    // It is held low during reset so that no write can commit under reset.
    assign accept = rst && (state_q == IDLE) && bus.req &&
                    (wait_cnt_q == 4'(ADDR_LAT)) && !addr_stall;

    // Next-state, counter and output-register logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        wr_d       = wr_q;
        mis_d      = mis_q;
        rbuf_d     = rbuf_q;
        rdata_d    = rdata_q;
        data_ok_d  = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = BUSY;
                    lat_cnt_d  = 4'd1;
                    wait_cnt_d = 4'd0;
                    wr_d       = bus.wr;
                    mis_d      = req_mis;
                    rbuf_d     = mem[idx];
                end else if (bus.req) begin
                    if (wait_cnt_q != 4'(ADDR_LAT)) wait_cnt_d = wait_cnt_q + 4'd1;
                end else begin
                    wait_cnt_d = 4'd0;
                end
            end
            BUSY: begin
                if (lat_cnt_q == 4'(DATA_LAT)) begin
                    state_d   = IDLE;
                    lat_cnt_d = 4'd0;
                end else if (!lat_stall) begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Entering the completion cycle: raise data_ok and present read data
        if ((state_d == BUSY) && (lat_cnt_d == 4'(DATA_LAT))) begin
            data_ok_d  = 1'b1;
            misalign_d = mis_d;
            if (!wr_d) rdata_d = rbuf_d;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            lat_cnt_q  <= 4'd0;
            wr_q       <= 1'b0;
            mis_q      <= 1'b0;
            rbuf_q     <= 32'h0;
            rdata_q    <= 32'h0;
            data_ok_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            wr_q       <= wr_d;
            mis_q      <= mis_d;
            rbuf_q     <= rbuf_d;
            rdata_q    <= rdata_d;
            data_ok_q  <= data_ok_d;
            misalign_q <= misalign_d;
        end
    end

    // RAM write port: enabled lanes commit at the acceptance edge; misaligned writes are dropped
    always_ff @(posedge clk) begin
        if (accept && bus.wr && !req_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    assign bus.addr_ok  = accept;
    assign bus.data_ok  = data_ok_q;
    assign bus.rdata    = rdata_q;
    assign bus.misalign = misalign_q;
    assign state_dbg    = (state_q == BUSY);
endmodule
